// File: rtl/sdfm_pkg.sv
// Shared constants for the sigma-delta channel datapath: sample width, default
// FIFO depth and the flag bit positions used by the register block.
package sdfm_pkg;
    localparam int SDFM_DATA_W     = 32;
    localparam int SDFM_FIFO_DEPTH = 16;

    localparam int SDFM_FLG_OVF   = 0;
    localparam int SDFM_FLG_UDF   = 1;
    localparam int SDFM_FLG_INT   = 2;
    localparam int SDFM_FLG_FULL  = 3;
    localparam int SDFM_FLG_EMPTY = 4;
endpackage

// File: rtl/filt_fifo_mem.sv
// Sample storage for filt_fifo: register array with one synchronous write port
// and an asynchronous read port, so the head is visible without a read cycle.
module filt_fifo_mem
    import sdfm_pkg::*;
#(
    parameter int DATA_W = SDFM_DATA_W,
    parameter int DEPTH  = SDFM_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/filt_fifo.sv
// Per-channel show-ahead sample FIFO behind the data filter: captures on the
// rising edge of the filter strobe, with threshold interrupt and sticky flags.
module filt_fifo
    import sdfm_pkg::*;
#(
    parameter int DATA_W = SDFM_DATA_W,
    parameter int DEPTH  = SDFM_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              SYSCLK,
    input  logic              SYSRST,
    input  logic [DATA_W-1:0] filt_data_out,
    input  logic              filt_data_update,
    input  logic              reg_fifoen,
    input  logic [CNT_W-1:0]  reg_fifolvl,
    input  logic              reg_fifoclr,
    input  logic              reg_flgclr,
    input  logic              rd_req,
    output logic [DATA_W-1:0] fifo_data,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_ovf,
    output logic              fifo_udf,
    output logic              fifo_int
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic              r_upd_d;
    logic              r_fifoen_d;
    logic              r_ovf;
    logic              r_udf;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_last;

    logic              w_wr;
    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_udf;
    logic [CNT_W-1:0]  w_eff_depth;
    logic [CNT_W-1:0]  w_lvl;
    logic [DATA_W-1:0] w_head;

    assign w_wr        = filt_data_update & ~r_upd_d;
    assign w_flush     = reg_fifoclr | (reg_fifoen ^ r_fifoen_d);
    assign w_eff_depth = reg_fifoen ? DEPTH_C : ONE_C;
    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == w_eff_depth);

    // A pop on a full FIFO frees the slot the same-cycle write lands in.
    assign w_pop     = rd_req & ~w_empty & ~w_flush;
    assign w_push    = w_wr & (~w_full | rd_req) & ~w_flush;
    assign w_set_ovf = w_wr & w_full & ~rd_req & ~w_flush;
    assign w_set_udf = rd_req & w_empty & ~w_flush;

    filt_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (SYSCLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (filt_data_out),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_upd_d    <= 1'b0;
            r_fifoen_d <= 1'b1;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
        end else begin
            r_upd_d    <= filt_data_update;
            r_fifoen_d <= reg_fifoen;
            r_ovf      <= w_set_ovf | (r_ovf & ~reg_flgclr);
            r_udf      <= w_set_udf | (r_udf & ~reg_flgclr);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    r_last   <= w_head;
                end
                r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Once drained, keep showing the last sample popped rather than stale RAM.
    assign w_lvl      = (reg_fifolvl == '0) ? ONE_C : reg_fifolvl;
    assign fifo_data  = w_empty ? r_last : w_head;
    assign fifo_cnt   = r_cnt;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign fifo_ovf   = r_ovf;
    assign fifo_udf   = r_udf;
    assign fifo_int   = (r_cnt >= w_lvl);
endmodule

// File: tb/tb_filt_fifo.sv
// Self-checking bench for filt_fifo: directed corner sequences, a threshold
// vector table, and random traffic against a queue-based reference model.
module tb_filt_fifo;
    logic        SYSCLK;
    logic        SYSRST;
    logic [31:0] filt_data_out;
    logic        filt_data_update;
    logic        reg_fifoen;
    logic [4:0]  reg_fifolvl;
    logic        reg_fifoclr;
    logic        reg_flgclr;
    logic        rd_req;
    logic [31:0] fifo_data;
    logic [4:0]  fifo_cnt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_ovf;
    logic        fifo_udf;
    logic        fifo_int;

    int n_tests = 0;
    int n_fail  = 0;

    filt_fifo dut (
        .SYSCLK           (SYSCLK),
        .SYSRST           (SYSRST),
        .filt_data_out    (filt_data_out),
        .filt_data_update (filt_data_update),
        .reg_fifoen       (reg_fifoen),
        .reg_fifolvl      (reg_fifolvl),
        .reg_fifoclr      (reg_fifoclr),
        .reg_flgclr       (reg_flgclr),
        .rd_req           (rd_req),
        .fifo_data        (fifo_data),
        .fifo_cnt         (fifo_cnt),
        .fifo_empty       (fifo_empty),
        .fifo_full        (fifo_full),
        .fifo_ovf         (fifo_ovf),
        .fifo_udf         (fifo_udf),
        .fifo_int         (fifo_int)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Reference model: contents as a queue plus flags and edge history.
    logic [31:0] m_q[$];
    logic        m_ovf, m_udf, m_upd_d, m_en_d;
    logic [31:0] m_last;

    typedef struct {
        logic        upd;
        logic [31:0] d;
        logic        rd;
        logic [4:0]  lvl;
        logic [4:0]  cnt;
        logic        intr;
        logic [31:0] data;
    } vec_t;
    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_upd_d = 1'b0;
        m_en_d  = 1'b1;
        m_last  = '0;
    endtask

    task automatic model_clock(input logic upd, input logic [31:0] d, input logic rd,
                               input logic clr, input logic flgclr, input logic en);
        int  eff;
        logic wr, full, empty, s_ovf, s_udf;
        eff   = en ? 16 : 1;
        wr    = upd && !m_upd_d;
        s_ovf = 1'b0;
        s_udf = 1'b0;
        if (clr || (en != m_en_d)) begin
            m_q.delete();
        end else begin
            full  = (m_q.size() == eff);
            empty = (m_q.size() == 0);
            s_udf = rd && empty;
            s_ovf = wr && full && !rd;
            if (rd && !empty) m_last = m_q.pop_front();
            if (wr && (!full || rd)) m_q.push_back(d);
        end
        m_ovf   = s_ovf || (m_ovf && !flgclr);
        m_udf   = s_udf || (m_udf && !flgclr);
        m_upd_d = upd;
        m_en_d  = en;
    endtask

    task automatic check_model(input string tag);
        int lvl;
        int sz;
        sz  = m_q.size();
        lvl = (reg_fifolvl == 0) ? 1 : int'(reg_fifolvl);
        chk({tag, ".cnt"},   32'(fifo_cnt), 32'(sz));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(sz == 0));
        chk({tag, ".full"},  32'(fifo_full), 32'(sz == (reg_fifoen ? 16 : 1)));
        chk({tag, ".ovf"},   32'(fifo_ovf), 32'(m_ovf));
        chk({tag, ".udf"},   32'(fifo_udf), 32'(m_udf));
        chk({tag, ".int"},   32'(fifo_int), 32'(sz >= lvl));
        chk({tag, ".data"},  fifo_data, (sz > 0) ? m_q[0] : m_last);
    endtask

    // One clock: drive, let the edge happen, advance the model, sample 1ns later.
    task automatic step(input logic upd, input logic [31:0] d, input logic rd,
                        input logic clr, input logic flgclr);
        filt_data_update = upd;
        filt_data_out    = d;
        rd_req           = rd;
        reg_fifoclr      = clr;
        reg_flgclr       = flgclr;
        @(posedge SYSCLK);
        model_clock(upd, d, rd, clr, flgclr, reg_fifoen);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'h1, 1'b0, 5'd4, 5'd1, 1'b0, 32'h1};
        tv[1]  = '{1'b0, 32'h0, 1'b0, 5'd4, 5'd1, 1'b0, 32'h1};
        tv[2]  = '{1'b1, 32'h2, 1'b0, 5'd4, 5'd2, 1'b0, 32'h1};
        tv[3]  = '{1'b0, 32'h0, 1'b0, 5'd4, 5'd2, 1'b0, 32'h1};
        tv[4]  = '{1'b1, 32'h3, 1'b0, 5'd4, 5'd3, 1'b0, 32'h1};
        tv[5]  = '{1'b0, 32'h0, 1'b0, 5'd4, 5'd3, 1'b0, 32'h1};
        tv[6]  = '{1'b1, 32'h4, 1'b0, 5'd4, 5'd4, 1'b1, 32'h1};
        tv[7]  = '{1'b0, 32'h0, 1'b1, 5'd4, 5'd3, 1'b0, 32'h2};
        tv[8]  = '{1'b0, 32'h0, 1'b1, 5'd4, 5'd2, 1'b0, 32'h3};
        tv[9]  = '{1'b0, 32'h0, 1'b1, 5'd4, 5'd1, 1'b0, 32'h4};
        tv[10] = '{1'b0, 32'h0, 1'b1, 5'd4, 5'd0, 1'b0, 32'h4};
        tv[11] = '{1'b1, 32'h5, 1'b0, 5'd0, 5'd1, 1'b1, 32'h5};
        tv[12] = '{1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 32'h5};

        SYSRST           = 1'b1;
        filt_data_out    = '0;
        filt_data_update = 1'b0;
        reg_fifoen       = 1'b1;
        reg_fifolvl      = 5'd1;
        reg_fifoclr      = 1'b0;
        reg_flgclr       = 1'b0;
        rd_req           = 1'b0;
        model_reset();
        #1;
        chk("rst.cnt",   32'(fifo_cnt), 32'd0);
        chk("rst.empty", 32'(fifo_empty), 32'd1);
        chk("rst.full",  32'(fifo_full), 32'd0);
        chk("rst.flags", {29'd0, fifo_ovf, fifo_udf, fifo_int}, 32'd0);
        chk("rst.data",  fifo_data, 32'd0);
        repeat (2) @(posedge SYSCLK);
        #1;
        SYSRST = 1'b0;

        // Reset mid-stream must clear immediately, without a clock edge.
        for (int i = 0; i < 5; i++) wr(32'h300 + 32'(i));
        chk("mid.cnt_pre", 32'(fifo_cnt), 32'd5);
        SYSRST = 1'b1;
        #1;
        model_reset();
        chk("mid.cnt",   32'(fifo_cnt), 32'd0);
        chk("mid.empty", 32'(fifo_empty), 32'd1);
        chk("mid.data",  fifo_data, 32'd0);
        chk("mid.int",   32'(fifo_int), 32'd0);
        @(posedge SYSCLK);
        #1;
        SYSRST = 1'b0;
        wr(32'h77);
        chk("mid.post_cnt", 32'(fifo_cnt), 32'd1);
        check_model("mid");
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, simultaneous push/pop on full, drain in order.
        for (int i = 0; i < 16; i++) wr(32'h100 + 32'(i));
        chk("fill.full", 32'(fifo_full), 32'd1);
        chk("fill.cnt",  32'(fifo_cnt), 32'd16);
        chk("fill.head", fifo_data, 32'h100);
        wr(32'hDEAD);
        chk("ovf.flag", 32'(fifo_ovf), 32'd1);
        chk("ovf.head", fifo_data, 32'h100);
        chk("ovf.cnt",  32'(fifo_cnt), 32'd16);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf.clr", 32'(fifo_ovf), 32'd0);
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        chk("wrrd.cnt",  32'(fifo_cnt), 32'd16);
        chk("wrrd.ovf",  32'(fifo_ovf), 32'd0);
        chk("wrrd.head", fifo_data, 32'h101);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", fifo_data, (i < 15) ? 32'h101 + 32'(i) : 32'h200);
            pop();
        end
        chk("drain.empty", 32'(fifo_empty), 32'd1);
        chk("drain.flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
        check_model("drain");

        // Level-held strobe yields one entry; pop on empty sets udf.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h55 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lvl.cnt",  32'(fifo_cnt), 32'd1);
        chk("lvl.data", fifo_data, 32'h55);
        pop();
        chk("lvl.empty", 32'(fifo_empty), 32'd1);
        chk("lvl.udf0",  32'(fifo_udf), 32'd0);
        pop();
        chk("udf.flag", 32'(fifo_udf), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("udf.clr", 32'(fifo_udf), 32'd0);

        // Single-entry mode, then re-enable flushes.
        wr(32'h9);
        reg_fifoen = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("se.flush", 32'(fifo_cnt), 32'd0);
        wr(32'hA);
        wr(32'hB);
        chk("se.cnt",  32'(fifo_cnt), 32'd1);
        chk("se.data", fifo_data, 32'hA);
        chk("se.ovf",  32'(fifo_ovf), 32'd1);
        chk("se.full", 32'(fifo_full), 32'd1);
        reg_fifoen = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("se.reen_cnt",   32'(fifo_cnt), 32'd0);
        chk("se.reen_empty", 32'(fifo_empty), 32'd1);
        check_model("se");

        // Threshold vector table.
        for (int i = 0; i < 13; i++) begin
            reg_fifolvl = tv[i].lvl;
            step(tv[i].upd, tv[i].d, tv[i].rd, 1'b0, 1'b0);
            chk($sformatf("tv%0d.cnt", i), 32'(fifo_cnt), 32'(tv[i].cnt));
            chk($sformatf("tv%0d.int", i), 32'(fifo_int), 32'(tv[i].intr));
            chk($sformatf("tv%0d.data", i), fifo_data, tv[i].data);
        end

        // Random traffic with alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 2000; i++) begin
            logic u, r, c, f;
            u = 1'($urandom_range(0, 1));
            r = ((i % 400) < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            c = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) reg_fifoen = ~reg_fifoen;
            if ($urandom_range(0, 49) == 0) reg_fifolvl = 5'($urandom_range(0, 17));
            step(u, $urandom, r, c, f);
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/filt_fifo.md
Name: filt_fifo

Overview:
Per-channel sample buffer directly downstream of the channel data filter. It captures each filtered 32-bit result on the rising edge of the filter's update strobe and queues it in a show-ahead FIFO for the register/bus interface. It raises a threshold interrupt and sticky overflow/underflow flags. Disabled mode acts as a single-entry holding register, so software sees one sample per interrupt.

Parameters:
DATA_W, 32, sample width (matches filter output)
DEPTH, 16, FIFO entries; power of two, 2..256
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
SYSCLK  in  1  system clock; all logic on rising edge
SYSRST  in  1  asynchronous, active-high reset
filt_data_out  in  DATA_W  filtered sample from channel filter
filt_data_update  in  1  filter update strobe; pulse or level, rising edge used
reg_fifoen  in  1  1 = FIFO mode, 0 = single-entry mode (effective depth 1)
reg_fifolvl  in  CNT_W  interrupt threshold; 0 treated as 1
reg_fifoclr  in  1  one-cycle flush pulse
reg_flgclr  in  1  one-cycle clear of ovf/udf flags
rd_req  in  1  one-cycle pop request from bus interface
fifo_data  out  DATA_W  head entry (show-ahead), valid when !fifo_empty
fifo_cnt  out  CNT_W  current occupancy
fifo_empty  out  1  cnt == 0
fifo_full  out  1  cnt == effective depth
fifo_ovf  out  1  sticky: sample dropped because full
fifo_udf  out  1  sticky: rd_req while empty
fifo_int  out  1  level interrupt: cnt >= max(reg_fifolvl,1)

Behaviour:
- Reset (async, SYSRST=1): pointers 0, fifo_cnt=0, fifo_empty=1, fifo_full=0, fifo_ovf=0, fifo_udf=0, fifo_int=0, fifo_data=0, edge-detect register=0.
- Write event wr = filt_data_update & ~upd_d (upd_d registered copy). Data sampled from filt_data_out in the same cycle as wr.
- Latency: fifo_cnt, fifo_empty, fifo_full and fifo_int update the cycle after wr/rd. fifo_data of a write into an empty FIFO is valid the cycle after wr.
- Pop: rd_req & !empty advances the read pointer. The next head appears on fifo_data the following cycle. If the FIFO becomes empty, fifo_data holds its last value.
- rd_req & empty: no pointer change; fifo_udf set.
- wr & full & !rd_req: sample discarded (newest dropped, contents intact); fifo_ovf set.
- wr & full & rd_req: pop and push both performed; cnt unchanged; no ovf.
- wr & empty & rd_req: push accepted; udf set; cnt becomes 1.
- Effective depth = DEPTH when reg_fifoen=1, else 1.
  - Toggling reg_fifoen flushes the FIFO (same as reg_fifoclr) on the cycle after the change.
- reg_fifoclr: pointers and cnt to 0 next cycle; has priority over a same-cycle wr/rd; flags unaffected.
- reg_flgclr: clears ovf/udf. A same-cycle set event wins (flag stays 1).
- Pointers are log2(DEPTH) bits and wrap naturally. cnt saturates neither way, because overflow/underflow are blocked.
- fifo_int is combinational from registered cnt and the threshold. A threshold > effective depth never fires.

Decomposition:
- Shared package sdfm_pkg: SDFM_DATA_W=32, default FIFO depth, and the flag bit-index constants used by the register block.
- Sub-module filt_fifo_mem: DEPTH x DATA_W register array, one synchronous write port, asynchronous read port addressed by the read pointer.
- Pointers, counter, flags and edge detect stay in filt_fifo.

Test Plan:
- Reset mid-stream: 5 writes, assert SYSRST -> all outputs 0 and fifo_empty=1 immediately (async); first post-reset write yields cnt=1.
- Fill/drain: 16 strobes with data 0x100..0x10F, then 16 pops -> fifo_data sequence 0x100..0x10F in order; full=1 after 16th; empty=1 after last pop; no flags.
- Overflow: full FIFO, write 0xDEAD -> dropped, ovf=1, head still 0x100. Write + rd_req same cycle -> cnt stays 16, no ovf. reg_flgclr -> ovf=0.
- Threshold: reg_fifolvl=4; 3 writes -> int=0; 4th write -> int=1 next cycle; one pop -> int=0. With reg_fifolvl=0, a single write -> int=1.
- Level strobe: filt_data_update held high 10 cycles -> exactly one entry (cnt=1). Pop on empty -> udf=1.
- Single-entry mode: reg_fifoen=0, two writes 0xA then 0xB without pop -> cnt=1, fifo_data=0xA, ovf=1. Re-enable -> flushed, cnt=0.
